// File: rtl/mmio_store_tap.sv
// mmio_store_tap: passive snooper on the core->memory bus.
//   Captures every store into the MMIO window (address[ADDR_BIT] = 1) into a
//   first-word-fall-through FIFO and drains it over a valid/ready stream.
//   Also raises a sticky halt flag when HALT_ADDR appears on the address bus.
// Ports:
//   clk, resetn            clock (rising edge), async active-low reset
//   address, data_out, we  snooped core bus (address, store data, write enable)
//   out_valid, out_ready   output stream handshake
//   out_addr, out_data     head entry of the FIFO (registered)
//   out_tstamp             capture cycle of the head entry (only with macro)
//   fifo_full              FIFO holds DEPTH entries
//   drop_count             saturating count of stores lost while full
//   halt                   sticky end-of-program flag
//   drained                halt and FIFO empty
// Optional feature macro: MMIO_STORE_TAP_TSTAMP_EN adds a free-running 32-bit
//   cycle counter whose value is stored with each entry and shown on out_tstamp.
module mmio_store_tap #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned ADDR_BIT  = 11,
   parameter logic [31:0] HALT_ADDR = 32'h0000_0FFC,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [31:0]      address,
   input  logic [31:0]      data_out,
   input  logic             we,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_addr,
   output logic [31:0]      out_data,
`ifdef MMIO_STORE_TAP_TSTAMP_EN
   output logic [31:0]      out_tstamp,
`endif
   output logic             fifo_full,
   output logic [CNT_W-1:0] drop_count,
   output logic             halt,
   output logic             drained
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   typedef struct packed {
`ifdef MMIO_STORE_TAP_TSTAMP_EN
      logic [31:0] tstamp;
`endif
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   entry_t             mem_q [DEPTH];
   entry_t             head_q, head_d;
   entry_t             push_entry;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]   count_q, count_d;
   logic               valid_q, valid_d;
   logic               full_q, full_d;
   logic               halt_q, halt_d;
   logic               drained_q, drained_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               push_req, pop, push_ok, drop;
`ifdef MMIO_STORE_TAP_TSTAMP_EN
   logic [31:0]        tstamp_q, tstamp_d;
`endif

   // Next-state logic for pointers, occupancy, head register and flags
   always_comb begin
      push_entry      = '0;
      push_entry.addr = address;
      push_entry.data = data_out;
`ifdef MMIO_STORE_TAP_TSTAMP_EN
      push_entry.tstamp = tstamp_q;
      tstamp_d          = tstamp_q + 32'd1;
`endif
      // halt_q is the pre-update value, so the store that sets halt is kept
      push_req = we && address[ADDR_BIT] && !halt_q;
      pop      = valid_q && out_ready;
      push_ok  = push_req && (!full_q || pop);
      drop     = push_req && full_q && !pop;

      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + OCC_W'(push_ok) - OCC_W'(pop);

      // Head comes from the incoming store when nothing older remains,
      // otherwise from storage; it holds its last value once empty.
      head_d = head_q;
      if (count_d != '0) begin
         head_d = (count_q == OCC_W'(pop)) ? push_entry : mem_q[rd_ptr_d];
      end

      valid_d   = (count_d != '0);
      full_d    = (count_d == OCC_FULL);
      drop_d    = (drop && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;
      halt_d    = halt_q || (address == HALT_ADDR);
      drained_d = halt_d && (count_d == '0);
   end

   // Control and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         head_q    <= '0;
         valid_q   <= 1'b0;
         full_q    <= 1'b0;
         drop_q    <= '0;
         halt_q    <= 1'b0;
         drained_q <= 1'b0;
`ifdef MMIO_STORE_TAP_TSTAMP_EN
         tstamp_q  <= '0;
`endif
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         head_q    <= head_d;
         valid_q   <= valid_d;
         full_q    <= full_d;
         drop_q    <= drop_d;
         halt_q    <= halt_d;
         drained_q <= drained_d;
`ifdef MMIO_STORE_TAP_TSTAMP_EN
         tstamp_q  <= tstamp_d;
`endif
      end
   end

   // Entry storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign out_valid  = valid_q;
   assign out_addr   = head_q.addr;
   assign out_data   = head_q.data;
`ifdef MMIO_STORE_TAP_TSTAMP_EN
   assign out_tstamp = head_q.tstamp;
`endif
   assign fifo_full  = full_q;
   assign drop_count = drop_q;
   assign halt       = halt_q;
   assign drained    = drained_q;

endmodule

// File: tb/tb_mmio_store_tap.sv
// tb_mmio_store_tap: randomized and directed stimulus against a queue-based
//   reference model; a monitor compares the stream head with the scoreboard.
module tb_mmio_store_tap;

   localparam int unsigned DEPTH     = 8;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned ADDR_BIT  = 11;
   localparam logic [31:0] HALT_ADDR = 32'h0000_0FFC;
   localparam int          DROP_MAX  = (1 << CNT_W) - 1;

   logic             clk;
   logic             resetn;
   logic [31:0]      address;
   logic [31:0]      data_out;
   logic             we;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_addr;
   logic [31:0]      out_data;
`ifdef MMIO_STORE_TAP_TSTAMP_EN
   logic [31:0]      out_tstamp;
`endif
   logic             fifo_full;
   logic [CNT_W-1:0] drop_count;
   logic             halt;
   logic             drained;

   mmio_store_tap #(
      .DEPTH    (DEPTH),
      .ADDR_BIT (ADDR_BIT),
      .HALT_ADDR(HALT_ADDR),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .address   (address),
      .data_out  (data_out),
      .we        (we),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
`ifdef MMIO_STORE_TAP_TSTAMP_EN
      .out_tstamp(out_tstamp),
`endif
      .fifo_full (fifo_full),
      .drop_count(drop_count),
      .halt      (halt),
      .drained   (drained)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] ts;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          occ;
   int          m_drop;
   logic        m_halt;
   logic [31:0] m_cyc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      occ    = 0;
      m_drop = 0;
      m_halt = 1'b0;
      m_cyc  = '0;
   endtask

   // Status outputs against the model after each clock edge
   task automatic check_status();
      chk("out_valid",  64'(out_valid),  64'(occ != 0));
      chk("fifo_full",  64'(fifo_full),  64'(occ == int'(DEPTH)));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      chk("halt",       64'(halt),       64'(m_halt));
      chk("drained",    64'(drained),    64'(m_halt && occ == 0));
   endtask

   // One bus cycle: drive inputs mid-cycle, advance the model, check after the edge
   task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
      logic pop, req;
      exp_t e;
      we = w; address = a; data_out = d; out_ready = r;
      pop = (occ > 0) && r;
      req = w && a[ADDR_BIT] && !m_halt;
      if (req) begin
         if (occ < int'(DEPTH) || pop) begin
            e.addr = a; e.data = d; e.ts = m_cyc;
            sb.push_back(e);
            occ++;
         end else if (m_drop < DROP_MAX) begin
            m_drop++;
         end
      end
      if (pop) occ--;
      if (a == HALT_ADDR) m_halt = 1'b1;
      m_cyc = m_cyc + 32'd1;
      @(posedge clk);
      #1;
      check_status();
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"},   64'(out_valid),  64'(0));
      chk({tag, "_addr"},    64'(out_addr),   64'(0));
      chk({tag, "_data"},    64'(out_data),   64'(0));
      chk({tag, "_full"},    64'(fifo_full),  64'(0));
      chk({tag, "_drop"},    64'(drop_count), 64'(0));
      chk({tag, "_halt"},    64'(halt),       64'(0));
      chk({tag, "_drained"}, 64'(drained),    64'(0));
   endtask

   // Reset mid-cycle, away from clock edges; returns 2 time units after a posedge
   task automatic do_reset();
      we = 1'b0; out_ready = 1'b0; address = 32'h0;
      resetn = 1'b0;
      #1;
      check_zero("async_rst");
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      resetn = 1'b1;
   endtask

   // Monitor: head of stream must match the oldest expected entry
   always @(negedge clk) begin
      if (resetn === 1'b1 && out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL head_unexpected actual=%0h required=none at %0t", out_addr, $time);
         end else begin
            chk("head_addr", 64'(out_addr), 64'(sb[0].addr));
            chk("head_data", 64'(out_data), 64'(sb[0].data));
`ifdef MMIO_STORE_TAP_TSTAMP_EN
            chk("head_tstamp", 64'(out_tstamp), 64'(sb[0].ts));
`endif
            if (out_ready === 1'b1) sb.delete(0);
         end
      end
   end

   initial begin
      logic        w, r;
      logic [31:0] a;
      resetn = 1'b0; we = 1'b0; address = '0; data_out = '0; out_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_zero("reset");
      resetn = 1'b1;

      // Single store, then stream empties again
      step(1'b1, 32'h800, 32'hDEADBEEF, 1'b1);
      drain(3);

      // Window filter: outside window and a read inside it
      step(1'b1, 32'h7FC, 32'h1111_1111, 1'b1);
      step(1'b1, 32'h400, 32'h2222_2222, 1'b1);
      step(1'b0, 32'h800, 32'h3333_3333, 1'b1);
      drain(2);

      // Full and drop: 10 stores with no consumer
      for (int i = 0; i < 10; i++) step(1'b1, 32'h800 + 32'(4 * i), $urandom, 1'b0);
      chk("drop_after_fill", 64'(drop_count), 64'(2));
      drain(DEPTH + 2);

      // Simultaneous push and pop while full
      for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 32'h900 + 32'(4 * i), $urandom, 1'b0);
      step(1'b1, 32'h9F0, 32'hCAFE_F00D, 1'b1);
      drain(DEPTH + 2);

      // Randomized traffic, alternating bursts of low and high consumer activity
      for (int i = 0; i < 600; i++) begin
         w = 1'($urandom_range(0, 1));
         a = $urandom & 32'hFFFF_FFFC;
         if (a == HALT_ADDR) a = a ^ 32'h4;
         if (((i / 50) % 2) == 0) r = ($urandom_range(0, 3) == 0);
         else                     r = ($urandom_range(0, 3) != 0);
         step(w, a, $urandom, r);
      end
      drain(DEPTH + 2);

      // Async reset with entries queued
      for (int i = 0; i < 3; i++) step(1'b1, 32'h840 + 32'(4 * i), $urandom, 1'b0);
      do_reset();
      step(1'b0, 32'h0, 32'h0, 1'b1);
      drain(2);

      // Halt: stores after the halt address are ignored
      step(1'b1, 32'h804, 32'hA5A5_0804, 1'b0);
      step(1'b0, HALT_ADDR, 32'h0, 1'b0);
      step(1'b1, 32'h808, 32'hA5A5_0808, 1'b0);
      step(1'b1, 32'h80C, 32'hA5A5_080C, 1'b1);
      drain(3);
      chk("drained_final", 64'(drained), 64'(1));

      // Store to the halt address itself is still captured
      do_reset();
      step(1'b1, 32'h810, $urandom, 1'b0);
      step(1'b1, HALT_ADDR, 32'hBEEF_0FFC, 1'b0);
      step(1'b1, 32'h814, $urandom, 1'b0);
      drain(4);

      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_store_tap.md
Name: mmio_store_tap

Overview:
- Sits on the core↔memory bus, downstream of the core; snoops core stores and passes them to off-chip/bench consumers.
- Captures every store into the MMIO window (address bit ADDR_BIT = 1), buffers it in a FIFO, and drains it over a valid/ready stream.
- Also detects the program-end address and raises a sticky halt flag.
- Does not drive the memory bus; purely a passive observer plus output stream.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- ADDR_BIT, 11, address bit that selects the MMIO window.
- HALT_ADDR, 32'h0000_0FFC, address whose appearance on the bus signals end of program.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- address  input  32  core bus address.
- data_out  input  32  core store data (core→memory).
- we  input  1  core write enable.
- out_valid  output  1  stream entry available.
- out_ready  input  1  consumer accepts entry.
- out_addr  output  32  address of the head entry.
- out_data  output  32  data of the head entry.
- fifo_full  output  1  FIFO holds DEPTH entries.
- drop_count  output  CNT_W  number of stores lost while full; saturating.
- halt  output  1  sticky; HALT_ADDR was seen on address.
- drained  output  1  halt && FIFO empty.

Behaviour:
- Reset (resetn=0, async): FIFO empty; out_valid=0; out_addr=0; out_data=0; fifo_full=0; drop_count=0; halt=0; drained=0. Reset mid-drain discards all entries. No push is sampled in the cycle resetn deasserts unless resetn is already 1 at that posedge.
- Push qualifier (sampled at posedge clk): push_req = we && address[ADDR_BIT] && !halt.
  - Capture is one entry per qualifying cycle; a store held for N cycles yields N entries.
  - {address, data_out} is written at tail.
- Pop: on posedge with out_valid && out_ready, the head advances.
- Output stream:
  - First-word-fall-through; out_addr/out_data are the head entry, registered.
  - out_valid rises the cycle after the first push into an empty FIFO (latency 1).
  - While out_valid=1 and out_ready=0, out_addr/out_data are stable.
- Full:
  - If the FIFO is full with no pop that cycle, push_req is dropped and drop_count is incremented.
  - drop_count saturates at 2^CNT_W−1.
- Simultaneous push and pop:
  - Both take effect and occupancy is unchanged.
  - When full, the push is accepted (no drop).
  - When occupancy is 1, the new entry becomes head the next cycle, with out_valid held at 1.
- Pointers: log2(DEPTH)-bit read/write pointers plus an occupancy counter of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- fifo_full = (count == DEPTH), registered with count.
- Halt:
  - halt is set at the first posedge where address == HALT_ADDR, independent of we.
  - Once set, halt stays 1 until reset.
  - A qualifying store in the same cycle that halt is set is still captured, because push_req uses the pre-update halt.
  - After halt, the FIFO keeps draining normally.
- drained = halt && (count == 0), registered.

Optional Feature:
- Macro: MMIO_STORE_TAP_TSTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter, reset to 0, increments every clk.
  - The counter value at capture is stored with each entry.
  - An extra output out_tstamp (32 bits) is presented and is aligned with out_addr/out_data.
  - The counter wraps silently.
- Undefined: no counter, no out_tstamp port; entry width is 64 bits.

Test Plan:
- Single store: we=1, address=0x800, data_out=0xDEADBEEF for 1 cycle, out_ready=1 → next cycle out_valid=1, out_addr=0x800, out_data=0xDEADBEEF; one cycle later out_valid=0.
- Window filter: stores to 0x7FC and 0x400, then a read (we=0) at 0x800 → out_valid stays 0, drop_count=0.
- Full/drop: out_ready=0; 10 consecutive stores to 0x800..0x824 (DEPTH=8) → fifo_full=1 after the 8th, drop_count=2. Then out_ready=1 → entries pop in order 0x800..0x81C, and drained stays 0.
- Simultaneous push/pop when full: FIFO full; assert a store and out_ready=1 in the same cycle → drop_count unchanged, fifo_full stays 1, the new entry is popped last.
- Halt: a store to 0x804, then address=0xFFC, then a store to 0x808 → halt=1 and stays high; 0x808 is not captured; drained=1 after 0x804 is popped.
- Async reset mid-drain: 3 entries queued, pull resetn low between clock edges → outputs zero immediately, without waiting for clk; after release, out_valid=0 and drop_count=0.
